// File: rtl/tea_stream_ctrl_pkg.sv
// Shared definitions for the TEA stream controller: default geometry and FSM states.
package tea_stream_ctrl_pkg;

  localparam int unsigned TEA_LATENCY = 32;
  localparam int unsigned TEA_DW      = 64;
  localparam int unsigned TEA_KW      = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DRAIN   = 2'd2,
    KEYLOAD = 2'd3
  } state_t;

endpackage

// File: rtl/tea_stream_ctrl_valid_pipe.sv
// Valid-bit shadow of the decryptor pipeline: one bit per slot, advancing with ena.
module tea_valid_pipe #(
  parameter int unsigned DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             din,
  output logic [DEPTH-1:0] q
);

  // Shift a new occupancy bit in whenever the array is enabled; hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (ena) begin
      q <= {q[DEPTH-2:0], din};
    end
  end

endmodule

// File: rtl/tea_stream_ctrl.sv
// Valid/ready wrapper around the fixed-latency, ena-gated TEA decryptor array.
// Tracks slot occupancy, gates ena on sink backpressure and drains the pipe before a key change.
module tea_stream_ctrl
  import tea_stream_ctrl_pkg::*;
#(
  parameter int unsigned LATENCY = TEA_LATENCY,
  parameter int unsigned DW      = TEA_DW,
  parameter int unsigned KW      = TEA_KW,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_block,
  input  logic             key_req,
  input  logic [KW-1:0]    key_in,
  output logic             key_ack,
  output logic             eng_ena,
  output logic [DW-1:0]    eng_in,
  output logic [KW-1:0]    eng_key,
  input  logic [DW-1:0]    eng_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_block,
  output logic             busy,
  output logic [CNT_W-1:0] blk_count
);

  localparam int unsigned IW = $clog2(LATENCY + 1);

  state_t             state;
  state_t             state_nxt;
  logic [LATENCY-1:0] vld_sr;
  logic [IW-1:0]      inflight;
  logic               stall;
  logic               advance;
  logic               accept;
  logic               handshake;

  tea_valid_pipe #(
    .DEPTH(LATENCY)
  ) u_valid_pipe (
    .clk (clk),
    .rst (rst),
    .ena (advance),
    .din (accept),
    .q   (vld_sr)
  );

  // Handshake, stall and enable decode; bubbles enter the array as zero.
  always_comb begin
    out_valid = vld_sr[LATENCY-1];
    stall     = out_valid & ~out_ready;
    advance   = ((state == RUN) || (state == DRAIN)) & ~stall;
    eng_ena   = advance;
    in_ready  = (state == RUN) & ~key_req & advance;
    accept    = in_valid & in_ready;
    handshake = out_valid & out_ready;
    eng_in    = accept ? in_block : '0;
    out_block = eng_out;
    key_ack   = (state == KEYLOAD);
    busy      = (state != RUN) || (inflight != '0);
  end

  // Next-state logic: a key request in RUN waits for the pipe to empty before loading.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (key_req) state_nxt = KEYLOAD;
      RUN:     if (key_req) state_nxt = DRAIN;
      DRAIN:   if (inflight == '0) state_nxt = KEYLOAD;
      KEYLOAD: state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // State, key register, occupancy and completion counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      eng_key   <= '0;
      inflight  <= '0;
      blk_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == KEYLOAD) begin
        eng_key <= key_in;
      end
      case ({accept, handshake})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
      if (handshake) begin
        blk_count <= blk_count + CNT_W'(1);
      end
    end
  end

endmodule
